// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operation; stage 2 computes and holds the result.
module alu_pipe #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_LE = 1'b0,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             carry_flag
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_GEN = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_ADC = 3'b110,
        OP_LE  = 3'b111
    } op_e;

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_cin_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             carry_flag_q;

    logic             s1_en;
    logic             s2_en;
    logic             s2_load;
    logic [WIDTH:0]   sum_d;
    logic             le;
    logic             in_rng;
    logic [SHW-1:0]   sh;
    logic             arith;

    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign s2_load  = s2_en && s1_valid_q;
    assign in_ready = s1_en;

    assign sh     = s1_b_q[SHW-1:0];
    assign in_rng = ({1'b0, s1_b_q} < (WIDTH+1)'(WIDTH));
    assign le     = SIGNED_LE ? ($signed(s1_a_q) <= $signed(s1_b_q))
                              : (s1_a_q <= s1_b_q);
    assign arith  = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB)
                 || (s1_op_q == OP_ADC);

    // All arithmetic is done one bit wider; the top bit becomes cout.
    always_comb begin
        sum_d = '0;
        unique case (s1_op_q)
            OP_ADD: sum_d = {1'b0, s1_a_q} + {1'b0, s1_b_q}
                          + (WIDTH+1)'(s1_cin_q);
            OP_SUB: sum_d = {1'b0, s1_a_q} + {1'b0, ~s1_b_q}
                          + (WIDTH+1)'(1);
            OP_AND: sum_d = {1'b0, s1_a_q & s1_b_q};
            OP_GEN: sum_d = in_rng ? {1'b0, WIDTH'(1) << sh}
                                   : {1'b1, {WIDTH{1'b0}}};
            OP_OR:  sum_d = {1'b0, s1_a_q | s1_b_q};
            OP_XOR: sum_d = {1'b0, s1_a_q ^ s1_b_q};
            OP_ADC: sum_d = {1'b0, s1_a_q} + {1'b0, s1_b_q}
                          + (WIDTH+1)'(carry_flag_q);
            OP_LE:  sum_d = {{WIDTH{1'b0}}, le};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_ADD;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_cin_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                s1_op_q    <= op_e'(op);
                s1_a_q     <= a;
                s1_b_q     <= b;
                s1_cin_q   <= cin;
            end
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
            end
            // Bubbles leave the last result in place rather than stale operands.
            if (s2_load) begin
                result_q <= sum_d[WIDTH-1:0];
                cout_q   <= sum_d[WIDTH];
                zero_q   <= (sum_d[WIDTH-1:0] == '0);
                if (arith) begin
                    carry_flag_q <= sum_d[WIDTH];
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign cout       = cout_q;
    assign zero       = zero_q;
    assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe: unsigned instance plus a
// signed-LE instance for the two's-complement compare.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic       carry_flag;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [2:0] s_op;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic       s_out_valid;
    logic [7:0] s_result;
    logic       s_cout;
    logic       s_zero;
    logic       s_carry_flag;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .SIGNED_LE(1'b0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zero(zero),
        .carry_flag(carry_flag)
    );

    alu_pipe #(.WIDTH(8), .SIGNED_LE(1'b1)) dut_s (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .cin(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .result(s_result), .cout(s_cout), .zero(s_zero),
        .carry_flag(s_carry_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] xa,
                         input logic [7:0] xb, input logic c);
        in_valid = 1'b1;
        op  = o;
        a   = xa;
        b   = xb;
        cin = c;
    endtask

    // Single op through an idle pipe with out_ready=1.
    task automatic run1(input string tag, input logic [2:0] o,
                        input logic [7:0] xa, input logic [7:0] xb,
                        input logic c, input logic [7:0] er,
                        input logic ec);
        drive(o, xa, xb, c);
        step();
        in_valid = 1'b0;
        step();
        chk({tag, ".v"}, 32'(out_valid), 32'd1);
        chk({tag, ".r"}, 32'(result), 32'(er));
        chk({tag, ".c"}, 32'(cout), 32'(ec));
        chk({tag, ".z"}, 32'(zero), 32'(er == 8'h00));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        op = 3'd0; a = 8'h00; b = 8'h00; cin = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0;
        s_op = 3'd0; s_a = 8'h00; s_b = 8'h00;

        step();
        step();
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.res", 32'(result), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.cf", 32'(carry_flag), 32'd0);
        reset = 1'b0;
        step();
        chk("rst.iready", 32'(in_ready), 32'd1);

        run1("add0", 3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run1("addc", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        chk("addc.cf", 32'(carry_flag), 32'd1);

        // ADD then ADC back to back: carry chains through carry_flag.
        drive(3'b000, 8'hFF, 8'h01, 1'b0);
        step();
        drive(3'b110, 8'h00, 8'h00, 1'b0);
        step();
        in_valid = 1'b0;
        chk("chain.add.r", 32'(result), 32'h00);
        chk("chain.add.c", 32'(cout), 32'd1);
        step();
        chk("chain.adc.v", 32'(out_valid), 32'd1);
        chk("chain.adc.r", 32'(result), 32'h01);
        chk("chain.adc.c", 32'(cout), 32'd0);
        chk("chain.adc.cf", 32'(carry_flag), 32'd0);

        run1("sub11", 3'b001, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1);
        run1("sub01", 3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        chk("sub01.cf", 32'(carry_flag), 32'd0);

        run1("gen3", 3'b011, 8'h00, 8'h03, 1'b0, 8'h08, 1'b0);
        run1("gen0", 3'b011, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0);
        run1("gen7", 3'b011, 8'h00, 8'h07, 1'b0, 8'h80, 1'b0);
        run1("gen8", 3'b011, 8'h00, 8'h08, 1'b0, 8'h00, 1'b1);
        run1("gen9", 3'b011, 8'h00, 8'h09, 1'b0, 8'h00, 1'b1);
        chk("gen9.cf", 32'(carry_flag), 32'd0);
        run1("and1", 3'b010, 8'h16, 8'h0F, 1'b0, 8'h06, 1'b0);
        run1("and2", 3'b010, 8'h28, 8'hF7, 1'b0, 8'h20, 1'b0);
        run1("or", 3'b100, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0);
        run1("xor", 3'b101, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0);
        run1("xor0", 3'b101, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0);
        run1("le12", 3'b111, 8'h01, 8'h02, 1'b0, 8'h01, 1'b0);
        run1("le22", 3'b111, 8'h02, 8'h02, 1'b0, 8'h01, 1'b0);
        run1("le32", 3'b111, 8'h03, 8'h02, 1'b0, 8'h00, 1'b0);
        run1("leu80", 3'b111, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0);

        s_in_valid = 1'b1;
        s_op = 3'b111; s_a = 8'h80; s_b = 8'h01;
        step();
        s_in_valid = 1'b0;
        step();
        chk("les80.v", 32'(s_out_valid), 32'd1);
        chk("les80.r", 32'(s_result), 32'h01);

        // Backpressure: two ops buffer, third waits for out_ready.
        out_ready = 1'b0;
        drive(3'b000, 8'h01, 8'h01, 1'b0);
        step();
        drive(3'b000, 8'hFF, 8'hFF, 1'b0);
        chk("bp.ir1", 32'(in_ready), 32'd1);
        step();
        drive(3'b000, 8'h03, 8'h03, 1'b0);
        chk("bp.ir0", 32'(in_ready), 32'd0);
        chk("bp.v1", 32'(out_valid), 32'd1);
        chk("bp.r1", 32'(result), 32'h02);
        chk("bp.cf1", 32'(carry_flag), 32'd0);
        step();
        chk("bp.hold.ir", 32'(in_ready), 32'd0);
        chk("bp.hold.r", 32'(result), 32'h02);
        chk("bp.hold.c", 32'(cout), 32'd0);
        chk("bp.hold.cf", 32'(carry_flag), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp.rel.ir", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp.o2.v", 32'(out_valid), 32'd1);
        chk("bp.o2.r", 32'(result), 32'hFE);
        chk("bp.o2.c", 32'(cout), 32'd1);
        chk("bp.o2.cf", 32'(carry_flag), 32'd1);
        step();
        chk("bp.o3.v", 32'(out_valid), 32'd1);
        chk("bp.o3.r", 32'(result), 32'h06);
        chk("bp.o3.cf", 32'(carry_flag), 32'd0);
        step();
        chk("bp.drain", 32'(out_valid), 32'd0);

        // Reset with two ops in flight.
        drive(3'b000, 8'hFF, 8'h01, 1'b0);
        step();
        drive(3'b000, 8'h10, 8'h20, 1'b0);
        step();
        chk("fl.v", 32'(out_valid), 32'd1);
        chk("fl.cf", 32'(carry_flag), 32'd1);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("fl.rst.v", 32'(out_valid), 32'd0);
        chk("fl.rst.cf", 32'(carry_flag), 32'd0);
        chk("fl.rst.r", 32'(result), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl.nostale", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 8-bit micro ALU fragment.
- Adds a valid/ready handshake on both sides, a persistent carry flag for chained multi-word arithmetic, extra logic ops, an out-of-range-detecting bit generator and a less-or-equal compare.
- Sits between the instruction decoder (upstream) and the register-file writeback (downstream).

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- SIGNED_LE, 0, 1 = LE op compares two's-complement; 0 = unsigned.
- SHW, $clog2(WIDTH), width of the GENBIT shift index; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage 1 can accept; transfer when in_valid && in_ready.
- op  in  3  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for ADD.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  WIDTH  result.
- cout  out  1  carry / flag bit of result.
- zero  out  1  result == 0.
- carry_flag  out  1  stored carry register.

Behaviour:
- Reset (one edge with reset=1):
  - s1_valid=0, out_valid=0, result=0, cout=0, zero=0, carry_flag=0.
  - Any in-flight operations are discarded; no output transfer occurs.
  - in_ready=1 in the cycle after reset deasserts.
- Pipeline control:
  - s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational from out_ready).
  - Stage 1 captures op/a/b/cin when s1_en. s1_valid becomes in_valid, or 0 if not presented.
  - Stage 2 computes from stage 1 and loads result/cout/zero when s2_en. out_valid becomes s1_valid.
- Timing and ordering:
  - Latency: op accepted at edge N → out_valid=1 after edge N+1.
  - Throughput: one op per cycle while out_ready=1.
  - Results leave in acceptance order; none dropped or duplicated.
  - While out_valid && !out_ready: result, cout and zero are held stable; at most 2 ops are buffered, then in_ready=0.
- Opcodes, computed in stage 2 at WIDTH+1 bits, {cout,result}:
  - 000 ADD: a + b + cin.
  - 001 SUB: a + ~b + 1; cout=1 means no borrow.
  - 010 AND: {0, a & b}.
  - 011 GENBIT: b < WIDTH → {0, 1<<b[SHW-1:0]}; b >= WIDTH → result=0, cout=1 (out-of-range flag).
  - 100 OR: {0, a | b}.
  - 101 XOR: {0, a ^ b}.
  - 110 ADC: a + b + carry_flag (cin ignored).
  - 111 LE: result = {0…0, a<=b}, cout=0; signedness per SIGNED_LE.
- Flags:
  - zero = (result==0), registered alongside result.
  - carry_flag loads cout on the same edge stage 2 loads an ADD, SUB or ADC. Other ops leave it unchanged.
  - Back-to-back ADD then ADC therefore chains correctly.
  - A stalled stage 2 does not update carry_flag.
- Simultaneous events: input and output transfers in the same cycle are legal. Reset dominates all.
- No X on outputs after reset; unknown op is impossible (3-bit fully decoded).

Test Plan (WIDTH=8, SIGNED_LE=0 unless stated; out_ready=1 unless stated):
- Reset, then ADD a=00 b=00 cin=0 → 2 cycles later out_valid=1, result=00, cout=0, zero=1; ADD a=FF b=01 cin=0 → result=00, cout=1, carry_flag=1.
- ADD FF+01 immediately followed by ADC 00+00 → second result=01, cout=0, carry_flag=0; SUB 01-01 → result=00, cout=1, zero=1; SUB 00-01 → result=FF, cout=0.
- GENBIT b=03 → 08, cout=0; b=00 → 01; b=09 → 00, cout=1; AND 16&0F → 06; AND 28&F7 → 20; OR/XOR 0F,F0 → FF/FF.
- LE 01<=02 → 01; 02<=02 → 01; 03<=02 → 00; with SIGNED_LE=1, 80<=01 → 01, while SIGNED_LE=0 gives 00.
- out_ready=0, issue 3 ops back-to-back → in_ready=0 after 2 accepted, outputs held stable; release out_ready → all 3 results appear in order on consecutive cycles, and the third op is accepted once ready returns.
- Reset asserted with 2 ops in flight → next cycle out_valid=0, carry_flag=0, no stale result emerges afterwards.
